// File: rtl/page_buffer_unload_pkg.sv
// Shared constants, state codes and stream beat type for page_buffer_unload.
// Optional feature macro: SKIP_INVALID_HALF_EN (see page_buffer_unload.sv).
package page_buffer_unload_pkg;

    localparam int          PAGE_BYTES_DEF = 8192;
    localparam logic [14:0] FLAG_ADDR_DEF  = 15'd8192;
    localparam logic [7:0]  INVALID_MARK   = 8'h55;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FLAG0  = 3'd1;
    localparam state_t ST_FLAG1  = 3'd2;
    localparam state_t ST_STREAM = 3'd3;
    localparam state_t ST_DRAIN  = 3'd4;
    localparam state_t ST_FIN    = 3'd5;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } stream_beat_t;

    function automatic logic is_invalid(input logic [7:0] b);
        return b == INVALID_MARK;
    endfunction

endpackage

// File: rtl/page_buffer_unload_if.sv
// Byte stream handshake between the unloader and its downstream consumer.
// master drives data/valid/last, slave returns ready.
interface page_buffer_unload_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/page_buffer_unload_skid_fifo.sv
// Two-entry output FIFO for returned RAM bytes (data plus last tag).
// The producer guarantees it never pushes into a full FIFO.
module unload_skid_fifo
    import page_buffer_unload_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  stream_beat_t push_beat,
    input  logic         pop,
    output stream_beat_t head,
    output logic         not_empty,
    output logic [1:0]   count
);

    stream_beat_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         pop_ok;

    assign pop_ok = pop && not_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop_ok};
        end
    end

    assign head      = mem[rd_ptr];
    assign not_empty = count != 2'd0;

endmodule

// File: rtl/page_buffer_unload.sv
// Unloads a completed page buffer RAM as a byte stream after reading two
// half-validity flags. SKIP_INVALID_HALF_EN skips halves flagged invalid.
module page_buffer_unload
    import page_buffer_unload_pkg::*;
#(
    parameter int          PAGE_BYTES = PAGE_BYTES_DEF,
    parameter logic [14:0] FLAG_ADDR  = FLAG_ADDR_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  half_invalid,
    output logic                        ram_en,
    output logic [14:0]                 ram_addr,
    input  logic [7:0]                  ram_dataout,
    page_buffer_unload_if.master        stream
);

    localparam logic [13:0] LAST_ADDR = 14'(PAGE_BYTES - 1);

    state_t       state;
    state_t       state_nxt;
    logic [13:0]  addr_cnt;
    logic [13:0]  stop_addr;
    logic [13:0]  start_addr;
    logic         in_flight;
    logic         in_flight_last;
    logic         flag1_pend;
    logic         mark_now;
    logic         none_left;
    logic         at_last;
    logic         issue;
    logic         room;
    logic         pop;
    logic         drain_ok;
    logic [2:0]   occ;

    stream_beat_t push_beat;
    stream_beat_t head;
    logic         fifo_valid;
    logic [1:0]   fifo_count;

    assign mark_now = is_invalid(ram_dataout);

`ifdef SKIP_INVALID_HALF_EN
    localparam logic [13:0] HALF_ADDR = 14'(PAGE_BYTES / 2);
    localparam logic [13:0] HALF_LAST = 14'(PAGE_BYTES / 2 - 1);

    logic hi1_now;

    // The second flag is still on the RAM bus in the first STREAM cycle.
    assign hi1_now    = flag1_pend ? mark_now : half_invalid[1];
    assign stop_addr  = hi1_now ? HALF_LAST : LAST_ADDR;
    assign start_addr = mark_now ? HALF_ADDR : 14'd0;
    assign none_left  = half_invalid[0] && hi1_now;
`else
    assign stop_addr  = LAST_ADDR;
    assign start_addr = 14'd0;
    assign none_left  = 1'b0;
`endif

    assign at_last = addr_cnt == stop_addr;
    assign pop     = fifo_valid && stream.out_ready;

    // Occupancy after this cycle's pop plus the read still in flight:
    // keeping it below two means every issued read has a FIFO slot.
    assign occ   = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, in_flight};
    assign room  = occ < 3'd2;
    assign issue = (state == ST_STREAM) && !none_left && room;

    assign drain_ok = !in_flight && (fifo_count == {1'b0, pop});

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FLAG0;
                end
            end
            ST_FLAG0: begin
                state_nxt = ST_FLAG1;
            end
            ST_FLAG1: begin
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (none_left) begin
                    state_nxt = ST_FIN;
                end else if (issue && at_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_ok) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            addr_cnt       <= 14'd0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            flag1_pend     <= 1'b0;
            half_invalid   <= 2'b00;
        end else begin
            state          <= state_nxt;
            in_flight      <= issue;
            in_flight_last <= issue && at_last;
            flag1_pend     <= state == ST_FLAG1;

            if (state == ST_IDLE && start) begin
                half_invalid <= 2'b00;
            end
            if (state == ST_FLAG1) begin
                half_invalid[0] <= mark_now;
            end
            if (flag1_pend) begin
                half_invalid[1] <= mark_now;
            end

            if (state == ST_FLAG1) begin
                addr_cnt <= start_addr;
            end else if (issue && !at_last) begin
                addr_cnt <= addr_cnt + 14'd1;
            end
        end
    end

    assign busy   = (state != ST_IDLE) && (state != ST_FIN);
    assign done   = state == ST_FIN;
    assign ram_en = (state == ST_FLAG0) || (state == ST_FLAG1) || issue;

    always_comb begin
        ram_addr = 15'd0;
        unique case (state)
            ST_FLAG0:  ram_addr = FLAG_ADDR;
            ST_FLAG1:  ram_addr = FLAG_ADDR + 15'd1;
            ST_STREAM: ram_addr = {1'b0, addr_cnt};
            default:   ram_addr = 15'd0;
        endcase
    end

    assign push_beat.last = in_flight_last;
    assign push_beat.data = ram_dataout;

    unload_skid_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_flight),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .not_empty (fifo_valid),
        .count     (fifo_count)
    );

    assign stream.out_data  = head.data;
    assign stream.out_valid = fifo_valid;
    assign stream.out_last  = fifo_valid && head.last;

endmodule

// File: tb/tb_page_buffer_unload.sv
// Bench for page_buffer_unload: RAM model, expected-byte queue per page,
// per-cycle stream compare, directed scenarios.
module tb_page_buffer_unload;
    import page_buffer_unload_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  half_invalid;
    logic        ram_en;
    logic [14:0] ram_addr;
    logic [7:0]  ram_dataout = 8'h00;

    page_buffer_unload_if sif ();

    page_buffer_unload dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .half_invalid (half_invalid),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .ram_dataout  (ram_dataout),
        .stream       (sif)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:8193];

    always @(posedge clk) begin
        if (ram_en) begin
            ram_dataout <= (ram_addr <= 15'd8193) ? ram[ram_addr] : 8'hxx;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] got [0:8191];
    int  cyc = 0;
    int  hs_count = 0;
    int  done_count = 0;
    int  done_cyc = 0;
    int  last_hs_cyc = 0;
    int  first_valid_cyc = -1;
    int  busy_rise_cyc = 0;
    bit  mon_on = 1'b0;
    bit  rand_ready = 1'b0;
    bit  prev_stall = 1'b0;
    bit  prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    initial begin
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        prev_busy = busy;
        if (mon_on) begin
            if (sif.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(sif.out_data), 32'hffff_ffff);
                end else begin
                    chk("out_data", 32'(sif.out_data), 32'(exp_q[0]));
                    chk("out_last", 32'(sif.out_last),
                        32'(exp_q.size() == 1));
                end
                if (sif.out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (hs_count < 8192) got[hs_count] = sif.out_data;
                    hs_count++;
                    last_hs_cyc = cyc;
                end
            end else begin
                chk("last_idle", 32'(sif.out_last), 32'd0);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(sif.out_valid), 32'd1);
                chk("stall_data", 32'(sif.out_data), 32'(prev_data));
                chk("stall_last", 32'(sif.out_last), 32'(prev_last));
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_data  = sif.out_data;
            prev_last  = sif.out_last;
            if (done) begin
                done_count++;
                done_cyc = cyc;
                chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
                chk("done_busy_low", 32'(busy), 32'd0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int k;
        n0 = done_count;
        k = 0;
        while (done_count == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 32'(done_count != n0), 32'd1);
    endtask

    task automatic run_page(input logic [7:0] f0, input logic [7:0] f1,
                            input bit rnd, input int mid_start);
        int lo;
        int hi;
        int n0;
        int k;
        ram[8192] = f0;
        ram[8193] = f1;
        lo = 0;
        hi = 8191;
`ifdef SKIP_INVALID_HALF_EN
        if (f0 == 8'h55) lo = 4096;
        if (f1 == 8'h55) hi = 4095;
`endif
        exp_q.delete();
        for (int a = lo; a <= hi; a++) exp_q.push_back(ram[a]);
        hs_count = 0;
        first_valid_cyc = -1;
        prev_stall = 1'b0;
        n0 = done_count;
        rand_ready = rnd;
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        if (mid_start > 0) begin
            k = 0;
            while (hs_count < mid_start && k < 20000) begin
                @(negedge clk);
                k++;
            end
            chk("reached_mid", 32'(hs_count >= mid_start), 32'd1);
            pulse_start();
        end
        wait_done(40000);
        repeat (5) @(negedge clk);
        rand_ready = 1'b0;
        chk("done_count", 32'(done_count - n0), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("byte_count", 32'(hs_count), 32'(hi - lo + 1));
        chk("half_invalid", 32'(half_invalid),
            32'({f1 == 8'h55, f0 == 8'h55}));
        if (hi >= lo) begin
            chk("first_latency", 32'(first_valid_cyc - busy_rise_cyc), 32'd4);
            chk("done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);
        end else begin
            chk("no_valid", 32'(first_valid_cyc), 32'hffff_ffff);
            chk("empty_done_lat", 32'(done_cyc - busy_rise_cyc), 32'd3);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {2'b00, busy, done, half_invalid, ram_en, ram_addr,
                   sif.out_data, sif.out_valid, sif.out_last}, 32'd0);
    endtask

    initial begin
        int k;
        int n0;
        for (int i = 0; i < 8192; i++) ram[i] = i[7:0];
        ram[8192] = 8'h00;
        ram[8193] = 8'h00;

        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);

        // full stream
        run_page(8'h00, 8'h00, 1'b0, 0);
        chk("pin_hs_full", 32'(hs_count), 32'd8192);
        chk("pin_byte255", 32'(got[255]), 32'h0000_00ff);
        chk("pin_byte256", 32'(got[256]), 32'h0000_0000);
        chk("pin_byte8191", 32'(got[8191]), 32'h0000_00ff);
        chk("pin_hi_full", 32'(half_invalid), 32'd0);

        // backpressure
        run_page(8'h00, 8'h00, 1'b1, 0);
        chk("pin_byte4097_bp", 32'(got[4097]), 32'h0000_0001);

        // first half invalid
        run_page(8'h55, 8'h00, 1'b0, 0);
        chk("pin_hi_01", 32'(half_invalid), 32'd1);
`ifdef SKIP_INVALID_HALF_EN
        chk("pin_hs_half", 32'(hs_count), 32'd4096);
`else
        chk("pin_hs_half", 32'(hs_count), 32'd8192);
`endif

        // both halves invalid
        run_page(8'h55, 8'h55, 1'b0, 0);
        chk("pin_hi_11", 32'(half_invalid), 32'd3);
`ifdef SKIP_INVALID_HALF_EN
        chk("pin_hs_none", 32'(hs_count), 32'd0);
`else
        chk("pin_hs_none", 32'(hs_count), 32'd8192);
`endif

        // reset mid-stream
        ram[8192] = 8'h00;
        ram[8193] = 8'h00;
        exp_q.delete();
        for (int a = 0; a < 8192; a++) exp_q.push_back(ram[a]);
        hs_count = 0;
        prev_stall = 1'b0;
        pulse_start();
        k = 0;
        while (hs_count < 100 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_100", 32'(hs_count >= 100), 32'd1);
        mon_on = 1'b0;
        n0 = done_count;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort_outputs");
        repeat (4) begin
            @(negedge clk);
            chk("done_in_reset", 32'(done), 32'd0);
        end
        chk("no_done_abort", 32'(done_count - n0), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        prev_stall = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        run_page(8'h00, 8'h00, 1'b0, 0);
        chk("pin_hs_after_rst", 32'(hs_count), 32'd8192);

        // start while busy
        run_page(8'h00, 8'h00, 1'b0, 50);
        chk("pin_hs_busy_start", 32'(hs_count), 32'd8192);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
